encoder_emulator: RTL and testbench



---
 rtl/encoder_emulator.sv | 122 ++++++++++++
 tb/tb_encoder_emulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_emulator.sv
// encoder_emulator
//   Bus-mapped plant model for the motor controller. Each channel converts
//   PWM drive, direction bits and enable into an emulated encoder line. The
//   edge rate comes from a phase accumulator stepped by a per-channel gain.
//   A signed position count and stall injection are available over the bus.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   din       bus write data
//   address   bus address
//   w_en      bus write strobe
//   r_en      bus read strobe
//   dout      registered bus read data, valid the cycle after r_en
//   pwm       PWM drive per channel
//   motor     direction bits: [1:0] channel 0, [3:2] channel 1
//             01 forward, 10 reverse, 00 coast, 11 brake
//   enable    motor driver enable
//   encoders  emulated encoder lines, registered
//
// Register map (offset from EMULATOR_ADDRESS)
//   0 CTRL    [0] run, [1] stall0, [2] stall1
//   1 GAIN_0
//   2 GAIN_1
//   3 POS_0   any write clears it
//   4 POS_1   any write clears it
//   5 STATUS  [1:0] encoders, [3:2] direction valid per channel
module encoder_emulator #(
  parameter logic [7:0] EMULATOR_ADDRESS = 8'h00,
  parameter int         ACC_WIDTH        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [1:0] pwm,
  input  logic [3:0] motor,
  input  logic       enable,
  output logic [1:0] encoders
);

  logic [2:0]                 ctrl;
  logic [1:0][7:0]            gain;
  logic [1:0][ACC_WIDTH-1:0]  acc;
  logic [1:0][7:0]            pos;

  logic [7:0]     offset;
  logic [1:0]     fwd;
  logic [1:0]     rev;
  logic [1:0]     dir_valid;
  logic [1:0]     adv;
  logic [1:0]     carry;
  logic [ACC_WIDTH:0] sum [2];
  logic [7:0]     rdata;

  assign offset = address - EMULATOR_ADDRESS;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    assign fwd[i]       = (motor[2*i +: 2] == 2'b01);
    assign rev[i]       = (motor[2*i +: 2] == 2'b10);
    assign dir_valid[i] = fwd[i] | rev[i];
    assign adv[i]       = ctrl[0] & enable & pwm[i] & dir_valid[i] & ~ctrl[1+i];
    // Extra top bit of the sum is the accumulator carry out.
    assign sum[i]       = {1'b0, acc[i]} + {{(ACC_WIDTH-7){1'b0}}, gain[i]};
    assign carry[i]     = adv[i] & sum[i][ACC_WIDTH];
  end

  always_comb begin
    rdata = 8'h00;
    case (offset)
      8'd0:    rdata = {5'b0, ctrl};
      8'd1:    rdata = gain[0];
      8'd2:    rdata = gain[1];
      8'd3:    rdata = pos[0];
      8'd4:    rdata = pos[1];
      8'd5:    rdata = {4'b0, dir_valid, encoders};
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      gain     <= '0;
      acc      <= '0;
      pos      <= '0;
      encoders <= '0;
      dout     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (adv[i]) begin
          acc[i] <= sum[i][ACC_WIDTH-1:0];
        end
        if (carry[i]) begin
          encoders[i] <= ~encoders[i];
          pos[i]      <= fwd[i] ? pos[i] + 8'd1 : pos[i] - 8'd1;
        end
      end

      // Bus writes come after the plant update so a POS clear beats a
      // simultaneous count.
      if (w_en) begin
        case (offset)
          8'd0:    ctrl    <= din[2:0];
          8'd1:    gain[0] <= din;
          8'd2:    gain[1] <= din;
          8'd3:    pos[0]  <= 8'h00;
          8'd4:    pos[1]  <= 8'h00;
          default: ;
        endcase
      end

      if (r_en) begin
        dout <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_encoder_emulator.sv
module tb_encoder_emulator;

  localparam int AW  = 8;
  localparam int MOD = 1 << AW;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [1:0] pwm;
  logic [3:0] motor;
  logic       enable;
  logic [1:0] encoders;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] m_ctrl;
  logic [7:0] m_gain [2];
  int         m_phase [2];
  logic [7:0] m_pos [2];
  logic [1:0] m_enc;
  logic [7:0] m_dout;

  encoder_emulator #(.EMULATOR_ADDRESS(8'h00), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en),
    .r_en(r_en), .dout(dout), .pwm(pwm), .motor(motor), .enable(enable),
    .encoders(encoders)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic int dir_of(input int ch);
    logic [1:0] f;
    f = motor[2*ch +: 2];
    if (f == 2'b01) return 1;
    if (f == 2'b10) return -1;
    return 0;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      8'd0: v = {5'b0, m_ctrl};
      8'd1: v = m_gain[0];
      8'd2: v = m_gain[1];
      8'd3: v = m_pos[0];
      8'd4: v = m_pos[1];
      8'd5: v = {4'b0, dir_of(1) != 0, dir_of(0) != 0, m_enc};
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One clock: advance the model from the currently driven inputs, then
  // compare the DUT just after the edge.
  task automatic cycle();
    logic [7:0] rd;
    rd = model_read(address);
    for (int ch = 0; ch < 2; ch++) begin
      if (m_ctrl[0] && enable && pwm[ch] && dir_of(ch) != 0 && !m_ctrl[1+ch]) begin
        m_phase[ch] += m_gain[ch];
        if (m_phase[ch] >= MOD) begin
          m_phase[ch] -= MOD;
          m_enc[ch] = ~m_enc[ch];
          m_pos[ch] = (dir_of(ch) > 0) ? m_pos[ch] + 8'd1 : m_pos[ch] - 8'd1;
        end
      end
    end
    if (rst) begin
      m_ctrl = '0; m_enc = '0; m_dout = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_gain[ch] = '0; m_phase[ch] = 0; m_pos[ch] = '0;
      end
    end else begin
      if (w_en) begin
        case (address)
          8'd0: m_ctrl = din[2:0];
          8'd1: m_gain[0] = din;
          8'd2: m_gain[1] = din;
          8'd3: m_pos[0] = 8'h00;
          8'd4: m_pos[1] = 8'h00;
          default: ;
        endcase
      end
      if (r_en) m_dout = rd;
    end
    @(posedge clk);
    #1;
    chk("encoders", {6'b0, encoders}, {6'b0, m_enc});
    chk("dout", dout, m_dout);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a; din = d; w_en = 1'b1;
    cycle();
    w_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input string tag, input logic [7:0] exp);
    address = a; r_en = 1'b1;
    cycle();
    r_en = 1'b0;
    chk(tag, dout, exp);
  endtask

  initial begin
    int budget;
    m_ctrl = '0; m_enc = '0; m_dout = '0;
    for (int ch = 0; ch < 2; ch++) begin
      m_gain[ch] = '0; m_phase[ch] = 0; m_pos[ch] = '0;
    end
    rst = 1'b1; din = '0; address = '0; w_en = 1'b0; r_en = 1'b0;
    pwm = '0; motor = '0; enable = 1'b0;
    cycle();
    rst = 1'b0;
    bus_read(8'd0, "reset_ctrl", 8'h00);
    bus_read(8'd3, "reset_pos0", 8'h00);

    // Forward, gain 64: a toggle every 4 advancing cycles
    bus_write(8'd0, 8'd1);
    bus_write(8'd1, 8'd64);
    enable = 1'b1; motor = 4'b0001; pwm = 2'b01;
    run(16);
    pwm = 2'b00;
    bus_read(8'd3, "fwd_pos0", 8'd4);
    bus_read(8'd4, "fwd_pos1", 8'd0);

    // Reverse
    bus_write(8'd3, 8'd0);
    motor = 4'b0010; pwm = 2'b01;
    run(16);
    pwm = 2'b00;
    bus_read(8'd3, "rev_pos0", 8'hFC);

    // Wrap: 126 + 8 forward counts lands on -122
    bus_write(8'd1, 8'd128);
    bus_write(8'd3, 8'd0);
    motor = 4'b0001; pwm = 2'b01;
    run(268);
    pwm = 2'b00;
    bus_read(8'd3, "wrap_pos0", 8'h86);

    // 50% duty
    bus_write(8'd1, 8'd64);
    bus_write(8'd3, 8'd0);
    for (int k = 0; k < 32; k++) begin
      pwm = (k % 4 < 2) ? 2'b01 : 2'b00;
      cycle();
    end
    pwm = 2'b00;
    bus_read(8'd3, "duty_pos0", 8'd4);

    // Stall keeps phase: two steps in, stall, resume
    pwm = 2'b01;
    run(2);
    pwm = 2'b00;
    bus_write(8'd0, 8'd3);
    pwm = 2'b01;
    run(20);
    pwm = 2'b00;
    bus_read(8'd3, "stall_pos0", 8'd4);
    bus_write(8'd0, 8'd1);
    pwm = 2'b01;
    run(2);
    pwm = 2'b00;
    bus_read(8'd3, "unstall_pos0", 8'd5);

    // No advance for brake, enable low, run clear
    pwm = 2'b11;
    motor = 4'b1111; run(100);
    motor = 4'b0001; enable = 1'b0; run(100);
    enable = 1'b1; pwm = 2'b00;
    bus_write(8'd0, 8'd0);
    pwm = 2'b11; run(100);
    pwm = 2'b00;
    bus_read(8'd3, "hold_pos0", 8'd5);
    bus_write(8'd0, 8'd1);

    // POS clear on the carry edge
    pwm = 2'b01;
    run(3);
    address = 8'd3; w_en = 1'b1;
    cycle();
    w_en = 1'b0; pwm = 2'b00;
    bus_read(8'd3, "clear_on_carry", 8'd0);
    bus_read(8'd6, "unmapped", 8'd0);

    // Reset mid-run with both lines high
    bus_write(8'd2, 8'd64);
    motor = 4'b0101; pwm = 2'b11;
    budget = 0;
    while (m_enc != 2'b11 && budget < 64) begin
      cycle();
      budget++;
    end
    chk("enc_both_high", {6'b0, m_enc}, 8'd3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_encoders", {6'b0, encoders}, 8'd0);
    bus_read(8'd0, "rst_ctrl", 8'd0);
    bus_read(8'd1, "rst_gain0", 8'd0);
    bus_read(8'd2, "rst_gain1", 8'd0);
    bus_read(8'd3, "rst_pos0", 8'd0);
    bus_read(8'd4, "rst_pos1", 8'd0);
    run(50);
    chk("rst_no_toggle", {6'b0, encoders}, 8'd0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      pwm     = 2'($urandom);
      motor   = 4'($urandom);
      enable  = ($urandom % 8) != 0;
      w_en    = ($urandom % 6) == 0;
      r_en    = 1'($urandom);
      address = 8'($urandom % 8);
      din     = 8'($urandom);
      if (w_en && address == 8'd0) din[0] = ($urandom % 4) != 0;
      rst     = ($urandom % 400) == 0;
      cycle();
    end
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
